regfile_wb_arbiter: RTL and testbench

- Owns the single write port (dr/in/ldreg) of the 8x16 LC-3b register file.
- Shares that port between two writeback requesters: A = ALU/execute path, B = memory-load path. Arbitration is round-robin.
- Keeps an 8-bit pending-write scoreboard that decode uses to detect hazards.
- Updates the LC-3b N/Z/P condition codes from written values. Sits between execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus for the register-file write arbiter: decode issue port,
// two writeback requesters, and the regfile write port, scoreboard and nzp.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dr;
  logic              issue_ready;

  logic              a_valid;
  logic [ADDR_W-1:0] a_dr;
  logic [DATA_W-1:0] a_data;
  logic              a_setcc;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_dr;
  logic [DATA_W-1:0] b_data;
  logic              b_setcc;
  logic              b_ready;

  logic              rf_ldreg;
  logic [ADDR_W-1:0] rf_dr;
  logic [DATA_W-1:0] rf_in;
  logic [2:0]        nzp;
  logic [NREGS-1:0]  busy;

  modport master (
    output issue_valid, issue_dr,
    output a_valid, a_dr, a_data, a_setcc,
    output b_valid, b_dr, b_data, b_setcc,
    input  issue_ready, a_ready, b_ready,
    input  rf_ldreg, rf_dr, rf_in, nzp, busy
  );

  modport slave (
    input  issue_valid, issue_dr,
    input  a_valid, a_dr, a_data, a_setcc,
    input  b_valid, b_dr, b_data, b_setcc,
    output issue_ready, a_ready, b_ready,
    output rf_ldreg, rf_dr, rf_in, nzp, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the LC-3b regfile write port, with a pending-write
// scoreboard for decode hazards and N/Z/P condition-code update.
//
// state  | meaning
// PRIO_A | A wins the next contested grant
// PRIO_B | B wins the next contested grant
module regfile_wb_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int PRIO_INIT = 0
) (
  input logic                clk_50,
  input logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  localparam prio_t PRIO_RST = (PRIO_INIT != 0) ? PRIO_B : PRIO_A;

  prio_t             prio_q, prio_d;
  logic              grant_a, grant_b, accept, issue_ok;
  logic [ADDR_W-1:0] sel_dr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_setcc;

  logic [NREGS-1:0]  busy_q, busy_d;
  logic              rf_ldreg_q;
  logic [ADDR_W-1:0] rf_dr_q;
  logic [DATA_W-1:0] rf_in_q;
  logic [2:0]        nzp_q;

  function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])   return 3'b100;
    else if (d == '0)  return 3'b010;
    else               return 3'b001;
  endfunction

  always_ff @(posedge clk_50) begin
    if (reset) prio_q <= PRIO_RST;
    else       prio_q <= prio_d;
  end

  // Pointer moves to the loser only when both sides competed.
  always_comb begin
    prio_d  = prio_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (bus.a_valid && bus.b_valid) begin
        if (prio_q == PRIO_A) begin
          grant_a = 1'b1;
          prio_d  = PRIO_B;
        end else begin
          grant_b = 1'b1;
          prio_d  = PRIO_A;
        end
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  always_comb begin
    accept    = grant_a | grant_b;
    sel_dr    = grant_b ? bus.b_dr    : bus.a_dr;
    sel_data  = grant_b ? bus.b_data  : bus.a_data;
    sel_setcc = grant_b ? bus.b_setcc : bus.a_setcc;
    issue_ok  = !reset && bus.issue_valid && !busy_q[bus.issue_dr];
  end

  // Clear first so a same-register issue on the write edge keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (rf_ldreg_q) busy_d[rf_dr_q] = 1'b0;
    if (issue_ok)   busy_d[bus.issue_dr] = 1'b1;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      rf_ldreg_q <= 1'b0;
      rf_dr_q    <= '0;
      rf_in_q    <= '0;
      nzp_q      <= 3'b010;
      busy_q     <= '0;
    end else begin
      rf_ldreg_q <= accept;
      busy_q     <= busy_d;
      if (accept) begin
        rf_dr_q <= sel_dr;
        rf_in_q <= sel_data;
        if (sel_setcc) nzp_q <= cc_of(sel_data);
      end
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.issue_ready = !reset && !busy_q[bus.issue_dr];
  assign bus.rf_ldreg    = rf_ldreg_q;
  assign bus.rf_dr       = rf_dr_q;
  assign bus.rf_in       = rf_in_q;
  assign bus.nzp         = nzp_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants, write pipeline, nzp,
// scoreboard set/clear races and mid-operation reset.
module tb_regfile_wb_arbiter;
  logic clk_50;
  logic reset;
  int   checks;
  int   failures;

  regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .PRIO_INIT(0)) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_50);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_dr = 3'd0;
    bus.a_valid = 1'b0; bus.a_dr = 3'd0; bus.a_data = 16'h0; bus.a_setcc = 1'b0;
    bus.b_valid = 1'b0; bus.b_dr = 3'd0; bus.b_data = 16'h0; bus.b_setcc = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] dr, input logic [15:0] d, input logic cc);
    bus.a_valid = 1'b1; bus.a_dr = dr; bus.a_data = d; bus.a_setcc = cc;
  endtask

  task automatic drive_b(input logic [2:0] dr, input logic [15:0] d, input logic cc);
    bus.b_valid = 1'b1; bus.b_dr = dr; bus.b_data = d; bus.b_setcc = cc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    idle();
    reset = 1'b1;
    drive_a(3'd1, 16'h1, 1'b1);
    drive_b(3'd2, 16'h2, 1'b1);
    bus.issue_valid = 1'b1;
    mid();
    check_eq("rst_a_ready", bus.a_ready, 0);
    check_eq("rst_b_ready", bus.b_ready, 0);
    check_eq("rst_issue_ready", bus.issue_ready, 0);
    step();
    check_eq("rst_ldreg", bus.rf_ldreg, 0);
    check_eq("rst_nzp", bus.nzp, 3'b010);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rf_dr", bus.rf_dr, 0);
    check_eq("rst_rf_in", bus.rf_in, 0);

    // single A write
    reset = 1'b0;
    idle();
    drive_a(3'd3, 16'h0011, 1'b1);
    mid();
    check_eq("t1_a_ready", bus.a_ready, 1);
    check_eq("t1_b_ready", bus.b_ready, 0);
    step();
    idle();
    check_eq("t1_ldreg", bus.rf_ldreg, 1);
    check_eq("t1_rf_dr", bus.rf_dr, 3);
    check_eq("t1_rf_in", bus.rf_in, 16'h0011);
    check_eq("t1_nzp", bus.nzp, 3'b001);
    step();
    check_eq("t1_ldreg_off", bus.rf_ldreg, 0);

    // contested round-robin
    drive_a(3'd1, 16'd5, 1'b0);
    drive_b(3'd2, 16'h8000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq($sformatf("t2_a_ready%0d", i), bus.a_ready, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("t2_b_ready%0d", i), bus.b_ready, (i % 2 == 1) ? 1 : 0);
      step();
      check_eq($sformatf("t2_ldreg%0d", i), bus.rf_ldreg, 1);
      check_eq($sformatf("t2_rf_dr%0d", i), bus.rf_dr, (i % 2 == 0) ? 1 : 2);
      check_eq($sformatf("t2_nzp%0d", i), bus.nzp, (i == 0) ? 3'b001 : 3'b100);
    end
    idle();
    step();

    // scoreboard set, ignored re-issue, clear on write
    bus.issue_valid = 1'b1; bus.issue_dr = 3'd4;
    mid();
    check_eq("t3_issue_ready", bus.issue_ready, 1);
    step();
    check_eq("t3_busy_set", bus.busy, 8'h10);
    mid();
    check_eq("t3_issue_blocked", bus.issue_ready, 0);
    step();
    check_eq("t3_busy_hold", bus.busy, 8'h10);
    bus.issue_valid = 1'b0;
    drive_b(3'd4, 16'h1234, 1'b0);
    mid();
    check_eq("t3_b_ready", bus.b_ready, 1);
    step();
    bus.b_valid = 1'b0;
    check_eq("t3_ldreg", bus.rf_ldreg, 1);
    check_eq("t3_busy_pre_clr", bus.busy, 8'h10);
    step();
    check_eq("t3_busy_clr", bus.busy, 8'h00);
    check_eq("t3_issue_ready4", bus.issue_ready, 1);

    // setcc coverage
    drive_a(3'd0, 16'h0000, 1'b1);
    step();
    idle();
    check_eq("t4_nzp_zero", bus.nzp, 3'b010);
    drive_b(3'd1, 16'h7FFF, 1'b0);
    step();
    idle();
    check_eq("t4_rf_in", bus.rf_in, 16'h7FFF);
    check_eq("t4_nzp_held", bus.nzp, 3'b010);
    step();

    // same-edge set/clear, different then same register
    bus.issue_valid = 1'b1; bus.issue_dr = 3'd5;
    step();
    bus.issue_valid = 1'b0;
    check_eq("t5_busy5", bus.busy, 8'h20);
    drive_a(3'd5, 16'd3, 1'b0);
    step();
    bus.a_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_dr = 3'd6;
    mid();
    check_eq("t5_issue_ready6", bus.issue_ready, 1);
    step();
    bus.issue_valid = 1'b0;
    check_eq("t5_busy_diff", bus.busy, 8'h40);
    drive_a(3'd6, 16'd9, 1'b0);
    step();
    bus.a_valid = 1'b0;
    step();
    check_eq("t5_busy6_clr", bus.busy, 8'h00);
    drive_a(3'd6, 16'd10, 1'b0);
    step();
    bus.a_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_dr = 3'd6;
    step();
    bus.issue_valid = 1'b0;
    check_eq("t5_busy_same", bus.busy, 8'h40);

    // reset right after a contested accept
    drive_a(3'd7, 16'h8001, 1'b1);
    drive_b(3'd2, 16'd5, 1'b0);
    bus.issue_valid = 1'b1; bus.issue_dr = 3'd7;
    mid();
    check_eq("t6_a_ready", bus.a_ready, 1);
    step();
    reset = 1'b1;
    bus.issue_dr = 3'd0;
    mid();
    check_eq("t6_rst_a_ready", bus.a_ready, 0);
    check_eq("t6_rst_b_ready", bus.b_ready, 0);
    check_eq("t6_rst_issue_ready", bus.issue_ready, 0);
    step();
    check_eq("t6_ldreg", bus.rf_ldreg, 0);
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_nzp", bus.nzp, 3'b010);
    check_eq("t6_rf_dr", bus.rf_dr, 0);
    reset = 1'b0;
    bus.issue_valid = 1'b0;
    mid();
    check_eq("t6_ptr_a_ready", bus.a_ready, 1);
    check_eq("t6_ptr_b_ready", bus.b_ready, 0);
    step();
    idle();
    check_eq("t6_post_rf_dr", bus.rf_dr, 7);
    check_eq("t6_post_nzp", bus.nzp, 3'b100);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
